// File: rtl/continuous_monitoring_system_pkg.sv
// Shared definitions for the continuous monitoring system and its trace-path neighbours.
// Revision: 1.0
`timescale 1ns/1ps
`default_nettype none

package continuous_monitoring_system_pkg;

  localparam int         AXI_DATA_WIDTH      = 200;
  localparam int         TRACE_SER_OUT_WIDTH = 64;
  localparam logic [7:0] TRACE_SER_SYNC_BYTE = 8'hA5;

  typedef enum logic {
    SER_IDLE = 1'b0,
    SER_SEND = 1'b1
  } trace_ser_state_t;

endpackage

`default_nettype wire

// File: rtl/trace_pkt_serializer.sv
// trace_pkt_serializer: splits one wide trace packet into LS-first OUT_WIDTH beats.
// Optional header beat per packet when TRACE_PKT_SERIALIZER_HEADER_EN is defined. Revision: 1.0
`timescale 1ns/1ps
`default_nettype none

module trace_pkt_serializer
  import continuous_monitoring_system_pkg::*;
#(
  parameter int IN_WIDTH  = AXI_DATA_WIDTH,
  parameter int OUT_WIDTH = TRACE_SER_OUT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 S_AXIS_tvalid,
  output logic                 S_AXIS_tready,
  input  logic [IN_WIDTH-1:0]  S_AXIS_tdata,
  input  logic                 S_AXIS_tlast,
  output logic                 M_AXIS_tvalid,
  input  logic                 M_AXIS_tready,
  output logic [OUT_WIDTH-1:0] M_AXIS_tdata,
  output logic                 M_AXIS_tlast,
  output logic                 busy,
  output logic [31:0]          sent_pkt_count
);

  localparam int NUM_BEATS = (IN_WIDTH + OUT_WIDTH - 1) / OUT_WIDTH;
  localparam int PAD_WIDTH = NUM_BEATS * OUT_WIDTH;
`ifdef TRACE_PKT_SERIALIZER_HEADER_EN
  localparam int BURST = NUM_BEATS + 1;
`else
  localparam int BURST = NUM_BEATS;
`endif
  localparam int               IDX_W    = (BURST > 1) ? $clog2(BURST) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BURST - 1);

  trace_ser_state_t       state;
  trace_ser_state_t       state_nxt;
  logic [IDX_W-1:0]       beat_idx;
  logic [IDX_W-1:0]       data_idx;
  logic [PAD_WIDTH-1:0]   pkt_q;
  logic                   last_q;
  logic [OUT_WIDTH-1:0]   beat_data;
  logic                   final_beat;
  logic                   out_fire;
  logic                   final_fire;
  logic                   in_fire;

`ifdef TRACE_PKT_SERIALIZER_HEADER_EN
  localparam logic [7:0] NUM_BEATS_B = 8'(NUM_BEATS);
  logic [15:0] hdr_cnt_q;
`endif

  assign final_beat = (state == SER_SEND) && (beat_idx == LAST_IDX);
  assign out_fire   = M_AXIS_tvalid & M_AXIS_tready;
  assign final_fire = out_fire & final_beat;
  assign in_fire    = S_AXIS_tvalid & S_AXIS_tready;

  always_comb begin
    state_nxt     = state;
    S_AXIS_tready = 1'b0;
    M_AXIS_tvalid = 1'b0;
    busy          = 1'b0;
    case (state)
      SER_IDLE: begin
        S_AXIS_tready = 1'b1;
        if (S_AXIS_tvalid) state_nxt = SER_SEND;
      end
      SER_SEND: begin
        M_AXIS_tvalid = 1'b1;
        busy          = 1'b1;
        // Ready opens in the final-beat cycle so a waiting packet follows with no bubble.
        S_AXIS_tready = final_beat & M_AXIS_tready;
        if (final_fire && !S_AXIS_tvalid) state_nxt = SER_IDLE;
      end
      default: state_nxt = SER_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= SER_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_q          <= '0;
      last_q         <= 1'b0;
      beat_idx       <= '0;
      sent_pkt_count <= '0;
`ifdef TRACE_PKT_SERIALIZER_HEADER_EN
      hdr_cnt_q      <= '0;
`endif
    end else begin
      if (final_fire) sent_pkt_count <= sent_pkt_count + 32'd1;
      if (in_fire) begin
        pkt_q    <= PAD_WIDTH'(S_AXIS_tdata);
        last_q   <= S_AXIS_tlast;
        beat_idx <= '0;
`ifdef TRACE_PKT_SERIALIZER_HEADER_EN
        // Header carries the count including a packet completing in this same cycle.
        hdr_cnt_q <= sent_pkt_count[15:0] + {15'd0, final_fire};
`endif
      end else if (final_fire) begin
        beat_idx <= '0;
      end else if (out_fire) begin
        beat_idx <= beat_idx + IDX_W'(1);
      end
    end
  end

`ifdef TRACE_PKT_SERIALIZER_HEADER_EN
  assign data_idx = beat_idx - IDX_W'(1);
`else
  assign data_idx = beat_idx;
`endif

  always_comb begin
    beat_data = '0;
    for (int k = 0; k < NUM_BEATS; k++) begin
      if (data_idx == IDX_W'(k)) beat_data = pkt_q[k*OUT_WIDTH +: OUT_WIDTH];
    end
`ifdef TRACE_PKT_SERIALIZER_HEADER_EN
    if (beat_idx == '0) begin
      beat_data       = '0;
      beat_data[31:0] = {hdr_cnt_q, TRACE_SER_SYNC_BYTE, NUM_BEATS_B};
    end
`endif
    M_AXIS_tdata = M_AXIS_tvalid ? beat_data : '0;
  end

  assign M_AXIS_tlast = last_q & final_beat;

endmodule

`default_nettype wire
